// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing a single hyperbus_fifo user port among NREQ requesters.
// One transaction in flight; completion is routed back to the owner, watchdog flags lost completions.
module hyperbus_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req_rrq,
   input  logic [NREQ-1:0]                req_wrq,
   input  logic [NREQ*ADDR_WIDTH-1:0]     req_adr,
   input  logic [NREQ*DATA_WIDTH-1:0]     req_dat,
   input  logic [NREQ*(DATA_WIDTH/8)-1:0] req_mask,
   output logic [NREQ-1:0]                req_gnt,
   output logic [NREQ-1:0]                req_done,
   output logic [NREQ-1:0]                req_rvalid,
   output logic [DATA_WIDTH-1:0]          req_rdat,
   output logic [NREQ-1:0]                req_err,
   output logic                           m_rrq,
   output logic                           m_wrq,
   output logic [ADDR_WIDTH-1:0]          m_adr,
   output logic [DATA_WIDTH-1:0]          m_dat,
   output logic [DATA_WIDTH/8-1:0]        m_mask,
   input  logic                           m_tx_done,
   input  logic                           m_rx_valid,
   input  logic [DATA_WIDTH-1:0]          m_rx_dat,
   output logic                           busy,
   output logic                           spurious
);

   localparam int unsigned MW      = DATA_WIDTH / 8;
   localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW      = IW + 1;
   localparam int unsigned WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt, win_idx;
   logic [CW-1:0]   cand;
   logic [NREQ-1:0] pend;
   logic            win, op_rd, cmpl, wrong, wd_hit;
   logic [WDW-1:0]  wdog;

   // Arbitration search, completion decode and next-state logic
   always_comb begin
      pend      = req_rrq | req_wrq;
      win       = 1'b0;
      win_idx   = '0;
      cand      = '0;
      ptr_nxt   = ptr;
      cmpl      = op_rd ? m_rx_valid : m_tx_done;
      wrong     = op_rd ? m_tx_done : m_rx_valid;
      wd_hit    = (TIMEOUT != 0) && (wdog == WD_LAST);
      state_nxt = state;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!win) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (pend[cand[IW-1:0]]) begin
               win     = 1'b1;
               win_idx = cand[IW-1:0];
            end
         end
      end
      if (win) ptr_nxt = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
      case (state)
         S_IDLE:  if (win) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (cmpl)        state_nxt = S_DONE;
            else if (wd_hit) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (cmpl) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Command latch, downstream strobes, completion routing and watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         op_rd      <= 1'b0;
         wdog       <= '0;
         req_gnt    <= '0;
         req_done   <= '0;
         req_rvalid <= '0;
         req_err    <= '0;
         req_rdat   <= '0;
         m_rrq      <= 1'b0;
         m_wrq      <= 1'b0;
         m_adr      <= '0;
         m_dat      <= '0;
         m_mask     <= '0;
         busy       <= 1'b0;
         spurious   <= 1'b0;
      end else begin
         req_done   <= '0;
         req_rvalid <= '0;
         req_err    <= '0;
         m_rrq      <= 1'b0;
         m_wrq      <= 1'b0;
         busy       <= (state_nxt != S_IDLE);
         case (state)
            S_IDLE: begin
               if (m_tx_done || m_rx_valid) spurious <= 1'b1;
               if (win) begin
                  req_gnt <= NREQ'(1) << win_idx;
                  op_rd   <= req_rrq[win_idx];
                  m_rrq   <= req_rrq[win_idx];
                  m_wrq   <= !req_rrq[win_idx];
                  m_adr   <= req_adr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  m_dat   <= req_dat[win_idx*DATA_WIDTH +: DATA_WIDTH];
                  m_mask  <= req_mask[win_idx*MW +: MW];
                  ptr     <= ptr_nxt;
                  wdog    <= '0;
               end
            end
            S_ISSUE: if (m_tx_done || m_rx_valid) spurious <= 1'b1;
            S_WAIT: begin
               wdog <= wdog + WDW'(1);
               if (wrong) spurious <= 1'b1;
               if (cmpl) begin
                  req_done   <= req_gnt;
                  req_rvalid <= op_rd ? req_gnt : '0;
                  if (op_rd) req_rdat <= m_rx_dat;
               end
            end
            S_DRAIN: begin
               if (wrong) spurious <= 1'b1;
               if (cmpl)  req_err <= req_gnt;
            end
            S_DONE:  req_gnt <= '0;
            default: req_gnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scoreboard bench for hyperbus_arbiter: directed requests, monitor checks every strobe/pulse.
module tb_hyperbus_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned MW   = DW / 8;
   localparam int unsigned TO   = 16;

   logic                 clk, rst_n;
   logic [NREQ-1:0]      req_rrq, req_wrq;
   logic [NREQ*AW-1:0]   req_adr;
   logic [NREQ*DW-1:0]   req_dat;
   logic [NREQ*MW-1:0]   req_mask;
   logic [NREQ-1:0]      req_gnt, req_done, req_rvalid, req_err;
   logic [DW-1:0]        req_rdat;
   logic                 m_rrq, m_wrq, m_tx_done, m_rx_valid, busy, spurious;
   logic [AW-1:0]        m_adr;
   logic [DW-1:0]        m_dat, m_rx_dat;
   logic [MW-1:0]        m_mask;

   hyperbus_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_rrq(req_rrq), .req_wrq(req_wrq), .req_adr(req_adr), .req_dat(req_dat),
      .req_mask(req_mask), .req_gnt(req_gnt), .req_done(req_done), .req_rvalid(req_rvalid),
      .req_rdat(req_rdat), .req_err(req_err), .m_rrq(m_rrq), .m_wrq(m_wrq), .m_adr(m_adr),
      .m_dat(m_dat), .m_mask(m_mask), .m_tx_done(m_tx_done), .m_rx_valid(m_rx_valid),
      .m_rx_dat(m_rx_dat), .busy(busy), .spurious(spurious)
   );

   typedef struct packed {
      logic            rd;
      logic [AW-1:0]   adr;
      logic [DW-1:0]   dat;
      logic [MW-1:0]   mask;
      logic [NREQ-1:0] gnt;
   } iss_t;

   typedef struct packed {
      logic [NREQ-1:0] done;
      logic [NREQ-1:0] rvalid;
      logic [NREQ-1:0] err;
      logic [DW-1:0]   rdat;
   } cpl_t;

   iss_t iss_q[$];
   cpl_t cpl_q[$];
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench hung");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every downstream strobe and every requester pulse consumes one expectation
   always @(negedge clk) begin : monitor
      iss_t ei;
      cpl_t ec;
      if (rst_n) begin
         if (m_rrq || m_wrq) begin
            if (iss_q.size() == 0) check("unexpected_issue", {m_rrq, m_wrq}, 0);
            else begin
               ei = iss_q.pop_front();
               check("issue_rrq", m_rrq, ei.rd);
               check("issue_wrq", m_wrq, !ei.rd);
               check("issue_adr", m_adr, ei.adr);
               check("issue_gnt", req_gnt, ei.gnt);
               if (!ei.rd) begin
                  check("issue_dat", m_dat, ei.dat);
                  check("issue_mask", m_mask, ei.mask);
               end
            end
         end
         if ((|req_done) || (|req_err) || (|req_rvalid)) begin
            if (cpl_q.size() == 0) check("unexpected_cpl", {req_done, req_rvalid, req_err}, 0);
            else begin
               ec = cpl_q.pop_front();
               check("cpl_done", req_done, ec.done);
               check("cpl_rvalid", req_rvalid, ec.rvalid);
               check("cpl_err", req_err, ec.err);
               check("cpl_gnt", req_gnt, ec.done | ec.err);
               if (|ec.rvalid) check("cpl_rdat", req_rdat, ec.rdat);
            end
         end
      end
   end

   task automatic set_req(input int i, input bit rd, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [MW-1:0] mask);
      req_rrq[i]            = rd;
      req_wrq[i]            = !rd;
      req_adr[i*AW +: AW]   = adr;
      req_dat[i*DW +: DW]   = dat;
      req_mask[i*MW +: MW]  = mask;
   endtask

   task automatic drop(input int i);
      req_rrq[i] = 1'b0;
      req_wrq[i] = 1'b0;
   endtask

   task automatic expect_txn(input int i, input bit rd, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, input logic [MW-1:0] mask,
                             input logic [DW-1:0] rdat, input bit err);
      iss_t ei;
      cpl_t ec;
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[i] = 1'b1;
      ei = '{rd: rd, adr: adr, dat: dat, mask: mask, gnt: oh};
      ec = '{done: err ? '0 : oh, rvalid: (rd && !err) ? oh : '0, err: err ? oh : '0, rdat: rdat};
      iss_q.push_back(ei);
      cpl_q.push_back(ec);
   endtask

   task automatic wait_issue(output bit ok);
      int n = 0;
      while (!(m_rrq || m_wrq) && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 40);
      if (!ok) check("issue_wait_bound", 0, 1);
   endtask

   // Completion arrives in WAIT cycle lat+1 after the issue cycle
   task automatic serve(input int i, input bit rd, input int lat, input logic [DW-1:0] rdat);
      bit ok;
      int n = 0;
      wait_issue(ok);
      if (ok) begin
         repeat (lat + 1) @(negedge clk);
         if (rd) begin
            m_rx_valid = 1'b1;
            m_rx_dat   = rdat;
         end else m_tx_done = 1'b1;
         @(negedge clk);
         m_rx_valid = 1'b0;
         m_tx_done  = 1'b0;
         m_rx_dat   = '0;
         while (!(req_done[i] || req_err[i]) && n < 10) begin
            @(negedge clk);
            n++;
         end
         if (n >= 10) check("cpl_wait_bound", 0, 1);
      end
      drop(i);
   endtask

   initial begin : stim
      bit ok;
      rst_n = 1'b0;
      req_rrq = '0; req_wrq = '0; req_adr = '0; req_dat = '0; req_mask = '0;
      m_tx_done = 1'b0; m_rx_valid = 1'b0; m_rx_dat = '0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {req_gnt, req_done, req_rvalid, req_err, m_rrq, m_wrq, busy, spurious}, 0);
      check("rst_m_adr", m_adr, 0);
      check("rst_m_dat", {m_dat, m_mask}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single write from requester 1
      expect_txn(1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, '0, 1'b0);
      set_req(1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
      serve(1, 1'b0, 0, '0);
      @(negedge clk);

      // single read from requester 2
      expect_txn(2, 1'b1, 32'h40, '0, 4'h0, 32'h12345678, 1'b0);
      set_req(2, 1'b1, 32'h40, '0, 4'h0);
      serve(2, 1'b1, 2, 32'h12345678);
      @(negedge clk);

      // completion in the last WAIT cycle before the watchdog fires still counts
      expect_txn(3, 1'b0, 32'h300, 32'hA5A5_0F0F, 4'h3, '0, 1'b0);
      set_req(3, 1'b0, 32'h300, 32'hA5A5_0F0F, 4'h3);
      serve(3, 1'b0, TO - 1, '0);
      @(negedge clk);

      // no completion within TIMEOUT WAIT cycles: late tx_done gives err only
      expect_txn(0, 1'b0, 32'h400, 32'h0BAD_F00D, 4'hC, '0, 1'b1);
      set_req(0, 1'b0, 32'h400, 32'h0BAD_F00D, 4'hC);
      serve(0, 1'b0, TO + 4, '0);
      @(negedge clk);

      // completion while idle is flagged and sticky, routes nowhere
      check("idle_busy", busy, 0);
      check("spurious_clear", spurious, 0);
      m_tx_done = 1'b1;
      @(negedge clk);
      m_tx_done = 1'b0;
      check("spurious_set", spurious, 1);
      repeat (3) @(negedge clk);
      check("spurious_sticky", spurious, 1);

      // reset during WAIT abandons the transaction
      iss_q.push_back('{rd: 1'b0, adr: 32'h200, dat: 32'h1111_2222, mask: 4'h1, gnt: 4'b0010});
      set_req(1, 1'b0, 32'h200, 32'h1111_2222, 4'h1);
      wait_issue(ok);
      @(negedge clk);
      check("wait_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rstw_ctrl", {req_gnt, req_done, req_rvalid, req_err, m_rrq, m_wrq, busy, spurious}, 0);
      check("rstw_m_adr", m_adr, 0);
      check("rstw_m_dat", {m_dat, m_mask, req_rdat}, 0);
      drop(1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // fairness: all hold requests; grant order 0,1,2,3,0
      expect_txn(0, 1'b0, 32'h1000, 32'h0000_00A0, 4'h1, '0, 1'b0);
      expect_txn(1, 1'b1, 32'h1004, '0, 4'h0, 32'hCAFE_0001, 1'b0);
      expect_txn(2, 1'b0, 32'h1008, 32'h0000_00A2, 4'h4, '0, 1'b0);
      expect_txn(3, 1'b1, 32'h100C, '0, 4'h0, 32'hCAFE_0003, 1'b0);
      expect_txn(0, 1'b1, 32'h1100, '0, 4'h0, 32'hCAFE_0010, 1'b0);
      set_req(0, 1'b0, 32'h1000, 32'h0000_00A0, 4'h1);
      set_req(1, 1'b1, 32'h1004, '0, 4'h0);
      set_req(2, 1'b0, 32'h1008, 32'h0000_00A2, 4'h4);
      set_req(3, 1'b1, 32'h100C, '0, 4'h0);
      serve(0, 1'b0, 0, '0);
      @(negedge clk);
      set_req(0, 1'b1, 32'h1100, '0, 4'h0);
      serve(1, 1'b1, 1, 32'hCAFE_0001);
      serve(2, 1'b0, 0, '0);
      serve(3, 1'b1, 3, 32'hCAFE_0003);
      serve(0, 1'b1, 0, 32'hCAFE_0010);

      repeat (4) @(negedge clk);
      check("iss_q_left", iss_q.size(), 0);
      check("cpl_q_left", cpl_q.size(), 0);
      check("final_spurious", spurious, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
